// File: rtl/prng_elem_sampler_pkg.sv
// Shared constants and FSM encoding for the PRNG element sampler.
package prng_elem_sampler_pkg;
  localparam int N_DEFAULT = 47;
  localparam int M_DEFAULT = 79;
  localparam int PRNG_W    = 96;

  localparam logic [2:0] ST_IDLE_ENC = 3'd0;
  localparam logic [2:0] ST_REQ_ENC  = 3'd1;
  localparam logic [2:0] ST_WAIT_ENC = 3'd2;
  localparam logic [2:0] ST_EMIT_ENC = 3'd3;
  localparam logic [2:0] ST_DONE_ENC = 3'd4;

  typedef enum logic [2:0] {
    ST_IDLE = ST_IDLE_ENC,
    ST_REQ  = ST_REQ_ENC,
    ST_WAIT = ST_WAIT_ENC,
    ST_EMIT = ST_EMIT_ENC,
    ST_DONE = ST_DONE_ENC
  } state_t;
endpackage

// File: rtl/prng_elem_sampler_if.sv
// Element stream handshake between the sampler and its consumer.
interface prng_elem_sampler_if
  import prng_elem_sampler_pkg::*;
#(
  parameter int M = M_DEFAULT
);
  logic [M-1:0] out_elem;
  logic         out_valid;
  logic         out_ready;
  logic         out_last;

  modport master (output out_elem, output out_valid, output out_last, input out_ready);
  modport slave  (input out_elem, input out_valid, input out_last, output out_ready);
endinterface

// File: rtl/prng_elem_sampler_bitbuf.sv
// Shift/append bit buffer: PRNG words are OR-ed in above the current fill,
// elements are taken LSB-first from the bottom.
module prng_elem_sampler_bitbuf
  import prng_elem_sampler_pkg::*;
#(
  parameter int M = M_DEFAULT,
  parameter int W = PRNG_W,
  localparam int BW = W + M - 1,
  localparam int FW = $clog2(W + M)
) (
  input  logic          clk,
  input  logic          rst_b,
  input  logic          clear,
  input  logic          append,
  input  logic [W-1:0]  word,
  input  logic          consume,
  output logic [M-1:0]  elem,
  output logic [FW-1:0] fill
);
  logic [BW-1:0] buf_reg, buf_next;
  logic [FW-1:0] fill_reg, fill_next;

  // Appends only happen with fill < M, so the shifted word always fits in BW bits.
  always_comb begin
    buf_next  = buf_reg;
    fill_next = fill_reg;
    if (clear) begin
      buf_next  = '0;
      fill_next = '0;
    end else if (append) begin
      buf_next  = buf_reg | (BW'(word) << fill_reg);
      fill_next = fill_reg + FW'(W);
    end else if (consume) begin
      buf_next  = buf_reg >> M;
      fill_next = fill_reg - FW'(M);
    end
  end

  always_ff @(posedge clk) begin
    if (rst_b) begin
      buf_reg  <= '0;
      fill_reg <= '0;
    end else begin
      buf_reg  <= buf_next;
      fill_reg <= fill_next;
    end
  end

  assign elem = buf_reg[M-1:0];
  assign fill = fill_reg;
endmodule

// File: rtl/prng_elem_sampler.sv
// Turns 96-bit PRNG words into COUNT m-bit element candidates per job.
// Optional: PRNG_SAMPLER_REJECT_ZERO_EN drops all-zero candidates internally.
module prng_elem_sampler
  import prng_elem_sampler_pkg::*;
#(
  parameter int M     = M_DEFAULT,
  parameter int COUNT = N_DEFAULT,
  parameter int W     = PRNG_W,
  localparam int FW = $clog2(W + M),
  localparam int CW = $clog2(COUNT + 1)
) (
  input  logic                  clk,
  input  logic                  rst_b,
  input  logic                  in_start,
  input  logic                  in_reseed,
  input  logic [W-1:0]          in_seed,
  output logic                  prng_req,
  output logic                  prng_mod,
  output logic [W-1:0]          prng_seed,
  input  logic [W-1:0]          prng_rng,
  input  logic                  prng_done,
  prng_elem_sampler_if.master   elem_if,
  output logic                  out_busy,
  output logic                  out_done
);
  state_t         state_reg, state_next;
  logic [CW-1:0]  ecnt_reg, ecnt_next;
  logic           reseed_reg, first_reg;
  logic [W-1:0]   seed_reg;
  logic           clear, append, consume;
  logic           have_elem, emit, valid;
  logic [M-1:0]   elem;
  logic [FW-1:0]  fill;

  prng_elem_sampler_bitbuf #(.M(M), .W(W)) u_bitbuf (
    .clk     (clk),
    .rst_b   (rst_b),
    .clear   (clear),
    .append  (append),
    .word    (prng_rng),
    .consume (consume),
    .elem    (elem),
    .fill    (fill)
  );

  assign have_elem = (fill >= FW'(M));

`ifdef PRNG_SAMPLER_REJECT_ZERO_EN
  logic cand_zero;
  assign cand_zero = (elem == '0);
  assign emit      = have_elem & ~cand_zero;
`else
  assign emit      = have_elem;
`endif

  always_ff @(posedge clk) begin
    if (rst_b) state_reg <= ST_IDLE;
    else       state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    ecnt_next  = ecnt_reg;
    clear      = 1'b0;
    append     = 1'b0;
    consume    = 1'b0;
    prng_req   = 1'b0;
    prng_mod   = 1'b0;
    valid      = 1'b0;
    out_busy   = 1'b0;
    out_done   = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (in_start) begin
          clear      = 1'b1;
          ecnt_next  = '0;
          state_next = ST_REQ;
        end
      end
      ST_REQ: begin
        out_busy   = 1'b1;
        prng_req   = 1'b1;
        prng_mod   = first_reg & reseed_reg;
        state_next = ST_WAIT;
      end
      ST_WAIT: begin
        out_busy = 1'b1;
        if (prng_done) begin
          append     = 1'b1;
          state_next = ST_EMIT;
        end
      end
      ST_EMIT: begin
        out_busy = 1'b1;
        if (!have_elem) begin
          state_next = ST_REQ;
        end else begin
          valid = emit;
`ifdef PRNG_SAMPLER_REJECT_ZERO_EN
          if (cand_zero) consume = 1'b1;
`endif
          if (emit && elem_if.out_ready) begin
            consume   = 1'b1;
            ecnt_next = ecnt_reg + CW'(1);
            if (ecnt_reg == CW'(COUNT - 1)) state_next = ST_DONE;
          end
        end
      end
      ST_DONE: begin
        // Leftover bits never carry into the next job.
        out_done   = 1'b1;
        clear      = 1'b1;
        state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst_b) begin
      ecnt_reg   <= '0;
      reseed_reg <= 1'b0;
      first_reg  <= 1'b0;
      seed_reg   <= '0;
    end else begin
      ecnt_reg <= ecnt_next;
      if (state_reg == ST_IDLE && in_start) begin
        seed_reg   <= in_seed;
        reseed_reg <= in_reseed;
        first_reg  <= 1'b1;
      end else if (state_reg == ST_REQ) begin
        first_reg  <= 1'b0;
      end
    end
  end

  assign prng_seed         = seed_reg;
  assign elem_if.out_valid = valid;
  assign elem_if.out_elem  = valid ? elem : '0;
  assign elem_if.out_last  = valid & (ecnt_reg == CW'(COUNT - 1));
endmodule

// File: tb/tb_prng_elem_sampler.sv
// Scoreboard bench: a PRNG responder feeds words and a bit-stream model,
// a negedge monitor compares every accepted element against the model.
`timescale 1ns/1ps
module tb_prng_elem_sampler;
  import prng_elem_sampler_pkg::*;
  localparam int M     = M_DEFAULT;
  localparam int COUNT = N_DEFAULT;
  localparam int W     = PRNG_W;

  typedef struct {
    logic [M-1:0] elem;
    logic         last;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst_b = 1'b1;
  logic         in_start = 1'b0;
  logic         in_reseed = 1'b0;
  logic [W-1:0] in_seed = '0;
  logic         prng_req, prng_mod;
  logic [W-1:0] prng_seed;
  logic [W-1:0] prng_rng = '0;
  logic         prng_done = 1'b0;
  logic         out_busy, out_done;

  prng_elem_sampler_if #(.M(M)) eif ();

  prng_elem_sampler #(.M(M), .COUNT(COUNT), .W(W)) dut (
    .clk       (clk),
    .rst_b     (rst_b),
    .in_start  (in_start),
    .in_reseed (in_reseed),
    .in_seed   (in_seed),
    .prng_req  (prng_req),
    .prng_mod  (prng_mod),
    .prng_seed (prng_seed),
    .prng_rng  (prng_rng),
    .prng_done (prng_done),
    .elem_if   (eif),
    .out_busy  (out_busy),
    .out_done  (out_done)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  bit           bitq[$];
  exp_t         expq[$];
  int           model_cnt = 0;
  logic [M-1:0] job_elems[$];
  int           hs_req[$];
  int           hs_cnt = 0;
  int           req_cnt = 0;
  logic         req_mods[$];
  logic [W-1:0] req_seeds[$];
  logic [W-1:0] word_q[$];
  bit           resp_en = 1'b1;
  int           resp_lat = 1;
  bit           prev_last_hs = 1'b0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [W-1:0] gen_word(input int n);
    logic [31:0] u;
    u = 32'(n);
    return {u ^ 32'h9e3779b9, 32'hdeadbeef + u, (u << 3) ^ 32'h0badf00d};
  endfunction

  // Reference: plain LSB-first bit stream chopped into M-bit elements.
  task automatic model_word(input logic [W-1:0] w);
    exp_t         e;
    logic [M-1:0] v;
    for (int i = 0; i < W; i++) bitq.push_back(w[i]);
    while (bitq.size() >= M && model_cnt < COUNT) begin
      for (int i = 0; i < M; i++) v[i] = bitq.pop_front();
`ifdef PRNG_SAMPLER_REJECT_ZERO_EN
      if (v == '0) continue;
`endif
      e.elem = v;
      e.last = (model_cnt == COUNT - 1);
      expq.push_back(e);
      model_cnt++;
    end
  endtask

  // PRNG responder
  initial begin
    logic [W-1:0] w;
    forever begin
      @(posedge clk); #1;
      if (resp_en && !rst_b && prng_req) begin
        req_cnt++;
        req_mods.push_back(prng_mod);
        req_seeds.push_back(prng_seed);
        repeat (resp_lat) @(posedge clk);
        #1;
        w = (word_q.size() > 0) ? word_q.pop_front() : gen_word(req_cnt);
        prng_rng  = w;
        prng_done = 1'b1;
        model_word(w);
        @(posedge clk); #1;
        prng_done = 1'b0;
`ifndef PRNG_SAMPLER_REJECT_ZERO_EN
        check("valid_after_done", 128'(eif.out_valid), 128'(1));
`endif
      end
    end
  end

  // Monitor / scoreboard
  always @(negedge clk) begin
    exp_t e;
    if (!rst_b) begin
      if (prev_last_hs) begin
        check("done_after_last", 128'(out_done), 128'(1));
        check("busy_fall", 128'(out_busy), 128'(0));
      end else if (out_done) begin
        check("spurious_done", 128'(out_done), 128'(0));
      end
      prev_last_hs = 1'b0;
      if (eif.out_valid) check("no_req_pending", 128'(prng_req), 128'(0));
      if (eif.out_valid && eif.out_ready) begin
        if (expq.size() == 0) begin
          check("unexpected_elem", 128'(eif.out_valid), 128'(0));
        end else begin
          e = expq.pop_front();
          check("elem", 128'(eif.out_elem), 128'(e.elem));
          check("last", 128'(eif.out_last), 128'(e.last));
        end
        job_elems.push_back(eif.out_elem);
        hs_req.push_back(req_cnt);
        hs_cnt++;
        prev_last_hs = eif.out_last;
      end
    end else begin
      prev_last_hs = 1'b0;
    end
  end

  task automatic check_zero_outputs(input string tag);
    check({tag, "_req"},   128'(prng_req), 128'(0));
    check({tag, "_mod"},   128'(prng_mod), 128'(0));
    check({tag, "_seed"},  128'(prng_seed), 128'(0));
    check({tag, "_elem"},  128'(eif.out_elem), 128'(0));
    check({tag, "_valid"}, 128'(eif.out_valid), 128'(0));
    check({tag, "_last"},  128'(eif.out_last), 128'(0));
    check({tag, "_busy"},  128'(out_busy), 128'(0));
    check({tag, "_done"},  128'(out_done), 128'(0));
  endtask

  task automatic start_job(input logic reseed, input logic [W-1:0] seed);
    bitq.delete(); expq.delete(); job_elems.delete(); hs_req.delete();
    req_mods.delete(); req_seeds.delete();
    model_cnt = 0; hs_cnt = 0; req_cnt = 0;
    @(posedge clk); #1;
    in_start = 1'b1; in_reseed = reseed; in_seed = seed;
    @(posedge clk); #1;
    in_start = 1'b0; in_reseed = 1'b0;
    check("req_after_start", 128'(prng_req), 128'(1));
  endtask

  task automatic wait_done(input int budget);
    int n = 0;
    while (out_done !== 1'b1 && n < budget) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= budget) check("done_timeout", 128'(out_done), 128'(1));
    @(posedge clk); #1;
    $display("job end: elems=%0d reqs=%0d", hs_cnt, req_cnt);
  endtask

  initial begin
    logic [M-1:0] held;
    logic [M-1:0] ones;
    int n;
    eif.out_ready = 1'b1;
    ones = '1;

    // Reset and idle-time prng_done
    repeat (2) @(posedge clk);
    #1;
    check_zero_outputs("reset");
    rst_b = 1'b0;
    prng_rng = gen_word(99); prng_done = 1'b1;
    @(posedge clk); #1;
    prng_done = 1'b0;
    @(posedge clk); #1;
    check("idle_done_valid", 128'(eif.out_valid), 128'(0));
    check("idle_done_busy", 128'(out_busy), 128'(0));

    // Reseed job, full length
    word_q.push_back(96'h123456789abcdef012345678);
    start_job(1'b1, 96'hffffffff);
    wait_done(3000);
    check("reqs_per_job", 128'(req_cnt), 128'(39));
    check("elems_per_job", 128'(job_elems.size()), 128'(COUNT));
    check("mod_first", 128'(req_mods[0]), 128'(1));
    check("mod_second", 128'(req_mods[1]), 128'(0));
    check("seed_fwd", 128'(req_seeds[0]), 128'(96'hffffffff));
    check("elem0_word", 128'(job_elems[0]), 128'(79'h56789abcdef012345678));

    // Straddle and backpressure
    resp_lat = 3;
    word_q.push_back('1);
    word_q.push_back(96'h5);
    start_job(1'b0, 96'h0123456789abcdef00112233);
    n = 0;
    while (!(eif.out_valid && hs_cnt == 4) && n < 500) begin
      @(posedge clk); #1;
      n++;
    end
    check("bp_reach", 128'(hs_cnt), 128'(4));
    eif.out_ready = 1'b0;
    held = eif.out_elem;
    repeat (5) begin
      @(posedge clk); #1;
      check("bp_valid", 128'(eif.out_valid), 128'(1));
      check("bp_elem", 128'(eif.out_elem), 128'(held));
      check("bp_noreq", 128'(prng_req), 128'(0));
    end
    eif.out_ready = 1'b1;
    @(posedge clk); #1;
    check("resume_hs", 128'(hs_cnt), 128'(5));
    check("resume_valid", 128'(eif.out_valid), 128'(1));
    @(posedge clk); #1;
    check("resume_b2b", 128'(hs_cnt), 128'(6));
    wait_done(3000);
    check("straddle_e0", 128'(job_elems[0]), 128'(ones));
    check("straddle_e1", 128'(job_elems[1]), 128'(79'hbffff));
    check("refill_after_e1", 128'(hs_req[2]), 128'(3));
    check("mod_no_reseed", 128'(req_mods[0]), 128'(0));
    resp_lat = 1;

    // Reset while waiting on the PRNG
    resp_en = 1'b0;
    start_job(1'b0, 96'habcdef);
    @(posedge clk); #1;
    check("abort_in_wait", 128'(out_busy & ~prng_req), 128'(1));
    rst_b = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check_zero_outputs("abort");
    rst_b = 1'b0;
    prng_rng = gen_word(7); prng_done = 1'b1;
    @(posedge clk); #1;
    prng_done = 1'b0;
    repeat (4) begin
      @(posedge clk); #1;
      check("late_done_valid", 128'(eif.out_valid), 128'(0));
      check("late_done_req", 128'(prng_req), 128'(0));
      check("late_done_busy", 128'(out_busy), 128'(0));
    end
    resp_en = 1'b1;

    // All-zero first word
    word_q.push_back('0);
    start_job(1'b0, 96'h42);
    wait_done(3000);
    check("zero_job_elems", 128'(job_elems.size()), 128'(COUNT));
`ifndef PRNG_SAMPLER_REJECT_ZERO_EN
    check("zero_emitted", 128'(job_elems[0]), 128'(0));
`else
    check("zero_dropped", 128'(job_elems[0] != '0), 128'(1));
`endif
    check("leftover_expected", 128'(expq.size()), 128'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/prng_elem_sampler.md
# prng_elem_sampler

Converts the raw 96-bit word stream of the ROLLO PRNG into a stream of m-bit GF(2^m) element candidates for key/encapsulation vector generation. Sits directly downstream of `prng`. It drives the PRNG request/seed handshake, buffers leftover bits across words, and emits exactly COUNT elements per job to the consumer through a valid/ready handshake.

## Interface
- `M`, default `` `M `` (79): element width in bits; legal range 1..96.
- `COUNT`, default `` `N `` (47): elements emitted per job; must be ≥1.
- `W`, default 96: PRNG word width; fixed to match `prng`.
- `clk`  in  1  single clock, rising edge.
- `rst_b`  in  1  **synchronous, active-high reset**. The name is kept for codebase consistency; 1 means reset.
- `in_start`  in  1  one-cycle pulse that starts a job; ignored while busy.
- `in_reseed`  in  1  sampled with `in_start`. When 1, the first PRNG request of the job carries `prng_mod=1`.
- `in_seed`  in  96  sampled with `in_start` and forwarded on `prng_seed`.
- `prng_req`  out  1  one-cycle request pulse to `prng.in_ready`.
- `prng_mod`  out  1  valid only with `prng_req`; drives `prng.in_mod`.
- `prng_seed`  out  96  registered copy of `in_seed`; drives `prng.in_seed`.
- `prng_rng`  in  96  `prng.out_rng`; sampled only in a cycle where `prng_done=1`.
- `prng_done`  in  1  `prng.out_ready`. The first high cycle after a request marks word valid; further high cycles are ignored until the next request.
- `out_elem`  out  M  element candidate.
- `out_valid`  out  1  element valid.
- `out_ready`  in  1  consumer accepts the element.
- `out_last`  out  1  high with `out_valid` on element COUNT-1.
- `out_busy`  out  1  high from the cycle after `in_start` until `out_done`.
- `out_done`  out  1  one-cycle pulse after the last element is accepted.

## Operation
- Bit buffer `buf` is W+M-1 bits wide. Fill counter `fill` covers 0..W+M-1. Element counter `ecnt` covers 0..COUNT.
- FSM states: IDLE, REQ, WAIT, EMIT, DONE.
  - **IDLE:** on `in_start`, latch the seed and `in_reseed`, clear `buf`/`fill`/`ecnt`, then go to REQ.
  - **REQ:** assert `prng_req` for one cycle. `prng_mod`=latched reseed flag on the first request of the job, 0 on every later request. Go to WAIT.
  - **WAIT:** on `prng_done`, set `buf |= prng_rng << fill` and `fill += W`, then go to EMIT.
  - **EMIT:**
    - If `fill < M`, go to REQ.
    - Otherwise `out_elem = buf[M-1:0]` and `out_valid=1`.
    - On `out_valid & out_ready`: `buf >>= M`, `fill -= M`, `ecnt++`.
    - If `ecnt` reaches COUNT, go to DONE.
  - **DONE:** pulse `out_done`, discard leftover bits, go to IDLE.
- Extraction is LSB-first. Bits never straddle jobs.
- `out_elem`/`out_valid` stay stable while `out_ready=0`. No PRNG request is issued while an element is pending.
- `in_start` is ignored in any state except IDLE.
- `prng_done` is ignored outside WAIT.
- Reset mid-operation returns to IDLE, clears all state, and drops any in-flight PRNG word.

## Timing
- All outputs reset to 0: `prng_req`, `prng_mod`, `prng_seed`, `out_elem`, `out_valid`, `out_last`, `out_busy`, `out_done`.
- `in_start` at cycle t → `prng_req` high at t+1.
- `prng_done` at cycle u → `out_valid` at u+1 (when `fill ≥ M`).
- Back-to-back accepts give one element per cycle while `fill ≥ M`. Refilling costs one REQ cycle plus the PRNG latency.
- `out_done` rises the cycle after the final handshake. `out_busy` falls in the same cycle.
- With M=79 and COUNT=47, a job issues ceil(3713/96)=39 PRNG requests.

## Configuration
- `PRNG_SAMPLER_REJECT_ZERO_EN`
  - **Defined:** an all-zero candidate is dropped internally. It consumes M bits in one EMIT cycle with `out_valid=0`, and `ecnt` is not incremented. The job therefore may issue more requests.
  - **Undefined:** zero candidates are emitted like any other value.

## Structure
- Shared package/`define.v`:
  - `` `N ``, `` `M ``, and the PRNG word width constant (96).
  - Sampler FSM state encoding localparams.
- One natural sub-module: `sampler_bitbuf`, the shift/append buffer with fill counter and ports `append`, `word`, `consume`, `elem`, `fill`.

## Test plan
- **Reset:** hold `rst_b=1` for 2 cycles → all outputs 0 and FSM in IDLE. `prng_done` pulses are ignored.
- **Reseed job:** `in_start` with `in_reseed=1`, `in_seed=96'hffffffff` → `prng_req` pulse with `prng_mod=1` and `prng_seed=96'hffffffff`. Return word 96'h1234…→ `out_elem = word[78:0]`. The second request has `prng_mod=0`.
- **Straddle:** word0=all-ones, word1=96'h0…05 → element 1 = `{word1[61:0], 17'h1ffff}` and `fill`=34 afterwards.
- **Backpressure:** `out_ready=0` for 5 cycles mid-job → `out_valid` held, `out_elem` unchanged, no `prng_req`. Elements resume one per cycle after release.
- **Zero rejection:** word0=0 → with the macro, no element from bits [78:0] and `ecnt` stays 0. Without the macro, `out_elem=0` is emitted.
- **Full job and reset abort:** COUNT=47 → 39 requests, `out_last` on the 47th element, `out_done` one cycle later. A separate run asserts reset in WAIT → IDLE; a late `prng_done` produces no output.
